// File: rtl/rr_arbiter4_buf.sv
// Round-robin arbiter over four neighbour channels feeding an external 4:1 mux,
// with a small output FIFO capturing the mux result for the PE datapath.
module rr_arbiter4_buf #(
  parameter int unsigned DATA_SIZE  = 8,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [3:0]                    in_valid,
  output logic [3:0]                    in_ready,
  output logic [1:0]                    sel,
  input  logic [DATA_SIZE-1:0]          mux_out,
  output logic [DATA_SIZE-1:0]          out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [1:0]           ptr;
  logic [1:0]           g;
  logic [1:0]           idx;
  logic                 found;
  logic                 full;
  logic                 grant;
  logic                 push;
  logic                 pop;
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [DATA_SIZE-1:0] mem [FIFO_DEPTH];

  // First requesting channel at or after ptr, scanning upward mod 4.
  always_comb begin
    g     = ptr;
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      idx = ptr + 2'(i);
      if (!found && in_valid[idx]) begin
        g     = idx;
        found = 1'b1;
      end
    end
  end

  assign full      = (count == CW'(FIFO_DEPTH));
  assign out_valid = (count != '0);
  assign grant     = (|in_valid) & ~full & rst_n;
  assign push      = grant;
  assign pop       = out_valid & out_ready;

  // sel is a function of registered state, in_valid and rst_n only, so the
  // external mux never closes a combinational loop back into this block.
  always_comb begin
    in_ready = '0;
    sel      = '0;
    if (rst_n) begin
      sel = grant ? g : ptr;
    end
    if (grant) begin
      in_ready[g] = 1'b1;
    end
  end

  assign out_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= mux_out;
        wr_ptr      <= wr_ptr + AW'(1);
        ptr         <= g + 2'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter4_buf.sv
// Directed-vector bench for rr_arbiter4_buf; the external mux is modelled
// from a fixed table of per-channel data indexed by sel.
module tb_rr_arbiter4_buf;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] in_valid;
  logic [3:0] in_ready;
  logic [1:0] sel;
  logic [7:0] mux_out;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] count;

  logic [7:0] chan_data [4];

  int unsigned total = 0;
  int unsigned bad   = 0;

  rr_arbiter4_buf #(.DATA_SIZE(8), .FIFO_DEPTH(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sel       (sel),
    .mux_out   (mux_out),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count)
  );

  always #5 clk = ~clk;

  assign mux_out = chan_data[sel];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    chan_data[0] = 8'h11;
    chan_data[1] = 8'h22;
    chan_data[2] = 8'hA5;
    chan_data[3] = 8'h44;

    // 1 reset with all channels requesting
    rst_n = 1'b0; in_valid = 4'b1111; out_ready = 1'b0;
    tick(); tick();
    chk("rst_in_ready", 32'(in_ready), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_sel", 32'(sel), 32'h0);
    chk("rst_out_data", 32'(out_data), 32'h0);

    // 2 single channel
    rst_n = 1'b1; in_valid = 4'b0100; out_ready = 1'b1;
    #1;
    chk("single_sel", 32'(sel), 32'h2);
    chk("single_in_ready", 32'(in_ready), 32'h4);
    tick();
    chk("single_out_valid", 32'(out_valid), 32'h1);
    chk("single_out_data", 32'(out_data), 32'hA5);
    chk("single_count", 32'(count), 32'h1);
    in_valid = 4'b0000;
    tick();
    chk("single_drain", 32'(count), 32'h0);

    // 5 wrap: ptr is now 3
    in_valid = 4'b1001;
    #1;
    chk("wrap_sel3", 32'(sel), 32'h3);
    chk("wrap_ready3", 32'(in_ready), 32'h8);
    tick();
    chk("wrap_sel0", 32'(sel), 32'h0);
    chk("wrap_ready0", 32'(in_ready), 32'h1);
    chk("wrap_data3", 32'(out_data), 32'h44);
    tick();
    chk("wrap_data0", 32'(out_data), 32'h11);
    chk("wrap_count", 32'(count), 32'h1);
    in_valid = 4'b0000;
    tick();
    chk("wrap_drain", 32'(count), 32'h0);

    // reset pulse brings ptr back to 0
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;

    // 3 round-robin with all channels held
    in_valid = 4'b1111; out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("rr_sel%0d", k), 32'(sel), 32'(k % 4));
      chk($sformatf("rr_ready%0d", k), 32'(in_ready), 32'(1 << (k % 4)));
      if (k > 0) chk($sformatf("rr_data%0d", k), 32'(out_data), 32'(chan_data[(k - 1) % 4]));
      tick();
    end
    chk("rr_data_last", 32'(out_data), 32'h11);
    chk("rr_count", 32'(count), 32'h1);
    in_valid = 4'b0000;
    tick();
    chk("rr_drain", 32'(count), 32'h0);

    // 4 full: ptr is 1, only channel 0 requests
    out_ready = 1'b0; in_valid = 4'b0001;
    tick(); tick();
    chk("full_count", 32'(count), 32'h2);
    chk("full_in_ready", 32'(in_ready), 32'h0);
    chk("full_sel_hold", 32'(sel), 32'h1);
    chk("full_head", 32'(out_data), 32'h11);
    out_ready = 1'b1;
    #1;
    chk("full_no_bypass", 32'(in_ready), 32'h0);
    tick();
    out_ready = 1'b0;
    chk("full_after_pop", 32'(count), 32'h1);
    chk("full_regrant", 32'(in_ready), 32'h1);
    tick();
    chk("full_refill", 32'(count), 32'h2);
    chk("full_block_again", 32'(in_ready), 32'h0);

    // 6 mid-operation reset with count=2 and ptr=1
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", 32'(in_ready), 32'h0);
    chk("mid_rst_sel", 32'(sel), 32'h0);
    tick();
    rst_n = 1'b1; in_valid = 4'b0000; out_ready = 1'b1;
    chk("mid_rst_count", 32'(count), 32'h0);
    chk("mid_rst_out_valid", 32'(out_valid), 32'h0);
    chk("mid_rst_out_data", 32'(out_data), 32'h0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("mid_rst_quiet%0d", k), 32'(out_valid), 32'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
